// File: rtl/tm1638_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tm1638_pkg
// Description : Shared constants for the TM1638 display driver: the three
//               command bytes, transaction identifiers, per-transaction last
//               bit indices and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tm1638_pkg;

    // Command bytes
    localparam logic [7:0] c_CMD_MODE = 8'h40;  // write data, auto-increment address
    localparam logic [7:0] c_CMD_ADDR = 8'hC0;  // set start address 0
    localparam logic [7:0] c_CMD_DISP = 8'h88;  // display on; low 3 bits = brightness

    // Transactions within one frame
    typedef logic [1:0] txn_t;
    localparam txn_t c_TXN_MODE = 2'd0;
    localparam txn_t c_TXN_ADDR = 2'd1;
    localparam txn_t c_TXN_DISP = 2'd2;

    // Last bit index of a transaction: address command plus 16 data bytes
    // form one 136-bit burst, the other two are single bytes.
    localparam logic [7:0] c_ADDR_LAST_BIT = 8'd135;
    localparam logic [7:0] c_CMD_LAST_BIT  = 8'd7;

    // Controller state encoding
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_BIT_LO = 3'd2;
    localparam state_t S_BIT_HI = 3'd3;
    localparam state_t S_GAP    = 3'd4;
    localparam state_t S_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex nibble to 7-segment code.
//               bit0 = a ... bit6 = g, bit7 (dp) always 0.
// Ports       : i_nibble [3:0] - hex digit in
//               o_seg    [7:0] - segment pattern out
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = 8'h00;
        case (i_nibble)
            4'h0: o_seg = 8'h3F;
            4'h1: o_seg = 8'h06;
            4'h2: o_seg = 8'h5B;
            4'h3: o_seg = 8'h4F;
            4'h4: o_seg = 8'h66;
            4'h5: o_seg = 8'h6D;
            4'h6: o_seg = 8'h7D;
            4'h7: o_seg = 8'h07;
            4'h8: o_seg = 8'h7F;
            4'h9: o_seg = 8'h6F;
            4'hA: o_seg = 8'h77;
            4'hB: o_seg = 8'h7C;
            4'hC: o_seg = 8'h39;
            4'hD: o_seg = 8'h5E;
            4'hE: o_seg = 8'h79;
            4'hF: o_seg = 8'h71;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tm1638_driver.sv
`default_nettype none
// ============================================================================
// Module      : tm1638_driver
// Description : Refreshes a TM1638 board (8 hex digits + 8 LEDs) with frames
//               of three serial transactions: mode command, address command
//               plus 16 data bytes, display command. Write-only bus.
// Ports       : clk, rst            - system clock, sync active-high reset
//               enable              - keep sending frames back-to-back
//               data[31:0]          - 8 hex digits, [31:28] leftmost
//               leds[7:0]           - discrete LEDs, [7] leftmost
//               brightness[2:0]     - display pulse width
//               tm_stb/tm_clk/tm_dio- TM1638 bus (all registered)
//               busy, frame_done    - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module tm1638_driver
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] data,
    input  logic [7:0]  leds,
    input  logic [2:0]  brightness,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_div, w_div_nxt;
    logic [7:0]  r_bit, w_bit_nxt;
    txn_t        r_txn, w_txn_nxt;
    logic [31:0] r_data;
    logic [7:0]  r_leds;
    logic [2:0]  r_bright;
    logic        r_stb, r_clk, r_dio, r_busy, r_done;
    logic        w_capture, w_tick, w_last_bit, w_in_txn, w_dio_nxt;
    logic [4:0]  w_idx;
    logic [7:0]  w_byte;
    logic [7:0]  w_seg [0:7];
    logic [7:0]  w_mux [0:16];

    // Address burst byte table: entry 0 is the address command, then
    // alternating digit segment code / LED byte, leftmost digit first.
    assign w_mux[0] = c_CMD_ADDR;
    for (genvar gi = 0; gi < 8; gi++) begin : g_digits
        hex_to_7seg u_seg (
            .i_nibble (r_data[31-4*gi -: 4]),
            .o_seg    (w_seg[gi])
        );
        assign w_mux[2*gi+1] = w_seg[gi];
        assign w_mux[2*gi+2] = {7'b0, r_leds[7-gi]};
    end

    assign w_tick     = (r_div == c_DIV_LAST);
    assign w_last_bit = (r_bit == ((r_txn == c_TXN_ADDR) ? c_ADDR_LAST_BIT : c_CMD_LAST_BIT));

    // Next-state logic. The divider runs only in timed states and reloads
    // to 0 on its terminal count; every other path leaves it at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = 8'd0;
        w_bit_nxt   = r_bit;
        w_txn_nxt   = r_txn;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_START;
                    w_capture   = 1'b1;
                    w_bit_nxt   = 8'd0;
                    w_txn_nxt   = c_TXN_MODE;
                end
            end
            S_START: begin
                if (w_tick) w_state_nxt = S_BIT_LO;
                else        w_div_nxt   = r_div + 8'd1;
            end
            S_BIT_LO: begin
                if (w_tick) w_state_nxt = S_BIT_HI;
                else        w_div_nxt   = r_div + 8'd1;
            end
            S_BIT_HI: begin
                if (w_tick) begin
                    if (w_last_bit) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_BIT_LO;
                        w_bit_nxt   = r_bit + 8'd1;
                    end
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    if (r_txn == c_TXN_DISP) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_START;
                        w_txn_nxt   = r_txn + 2'd1;
                        w_bit_nxt   = 8'd0;
                    end
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte carrying the bit about to go out; looked up with the next bit
    // index so tm_dio is registered on the same edge tm_clk falls.
    always_comb begin
        w_byte = 8'h00;
        w_idx  = w_bit_nxt[7:3];
        case (r_txn)
            c_TXN_MODE: w_byte = c_CMD_MODE;
            c_TXN_ADDR: w_byte = (w_idx > 5'd16) ? 8'h00 : w_mux[w_idx];
            default:    w_byte = c_CMD_DISP | {5'b0, r_bright};
        endcase
    end

    assign w_in_txn  = (w_state_nxt == S_START) || (w_state_nxt == S_BIT_LO) ||
                       (w_state_nxt == S_BIT_HI);
    assign w_dio_nxt = ((w_state_nxt == S_BIT_LO) && (r_state != S_BIT_LO)) ?
                       w_byte[w_bit_nxt[2:0]] : r_dio;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_div    <= 8'd0;
            r_bit    <= 8'd0;
            r_txn    <= c_TXN_MODE;
            r_data   <= 32'd0;
            r_leds   <= 8'd0;
            r_bright <= 3'd0;
            r_stb    <= 1'b1;
            r_clk    <= 1'b1;
            r_dio    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_txn   <= w_txn_nxt;
            if (w_capture) begin
                r_data   <= data;
                r_leds   <= leds;
                r_bright <= brightness;
            end
            r_stb  <= ~w_in_txn;
            r_clk  <= (w_state_nxt != S_BIT_LO);
            r_dio  <= w_dio_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign tm_stb     = r_stb;
    assign tm_clk     = r_clk;
    assign tm_dio     = r_dio;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_tm1638_driver
// Description : Scoreboard bench for tm1638_driver. Stimulus pushes the byte
//               stream and transaction lengths each frame must produce; a
//               monitor decodes the serial bus and checks against them, plus
//               start/gap timing, frame length and frame_done spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tm1638_driver;

    localparam int CLK_DIV   = 2;
    localparam int FRAME_CYC = 152 * 2 * CLK_DIV + 3 * CLK_DIV + 3 * CLK_DIV + 1;
    localparam int PERIOD    = FRAME_CYC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] data = 32'd0;
    logic [7:0]  leds = 8'd0;
    logic [2:0]  brightness = 3'd0;
    logic        tm_stb, tm_clk, tm_dio, busy, frame_done;

    tm1638_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data       (data),
        .leds       (leds),
        .brightness (brightness),
        .tm_stb     (tm_stb),
        .tm_clk     (tm_clk),
        .tm_dio     (tm_dio),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model
    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0] exp_bytes [$];
    int         exp_lens  [$];
    int         frames_exp = 0;

    task automatic push_frame(input logic [31:0] d, input logic [7:0] l, input logic [2:0] b);
        logic [3:0] nib;
        exp_lens.push_back(8);
        exp_bytes.push_back(8'h40);
        exp_lens.push_back(8 * 17);
        exp_bytes.push_back(8'hC0);
        for (int k = 0; k < 8; k++) begin
            nib = d[31-4*k -: 4];
            exp_bytes.push_back(seg_tab[nib]);
            exp_bytes.push_back({7'b0, l[7-k]});
        end
        exp_lens.push_back(8);
        exp_bytes.push_back(8'h88 + {5'b0, b});
        frames_exp++;
    endtask

    // Monitor
    int         nbits = 0, lead = 0, hi_cnt = 0, busy_len = 0, done_cnt = 0;
    int         done_times [$];
    bit         lead_done = 1'b1, gap_armed = 1'b0;
    logic       prev_stb = 1'b1, prev_clk = 1'b1, prev_busy = 1'b0, prev_done = 1'b0;
    logic [7:0] shreg = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0; lead_done = 1'b1; gap_armed = 1'b0; busy_len = 0; hi_cnt = 0;
        end else begin
            if (frame_done) begin
                check("done_width", int'(prev_done), 0);
                done_cnt++;
                done_times.push_back(cyc);
                gap_armed = 1'b0;
            end
            if (busy) busy_len++;
            else if (prev_busy) begin
                check("frame_len", busy_len, FRAME_CYC);
                busy_len = 0;
            end
            if (!tm_stb && prev_stb) begin
                if (gap_armed) check("gap_len", hi_cnt, CLK_DIV);
                nbits = 0; lead = 1; lead_done = 1'b0;
            end else if (!tm_stb) begin
                if (!lead_done) begin
                    if (tm_clk) lead++;
                    else begin
                        check("start_len", lead, CLK_DIV);
                        lead_done = 1'b1;
                    end
                end
                if (!prev_clk && tm_clk) begin
                    shreg = {tm_dio, shreg[7:1]};
                    nbits++;
                    if (nbits % 8 == 0) begin
                        if (exp_bytes.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL byte: got %02h, required none", shreg);
                        end else
                            check("byte", int'(shreg), int'(exp_bytes.pop_front()));
                    end
                end
            end
            if (tm_stb && !prev_stb) begin
                if (exp_lens.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL txn_len: got %0d bits, required none", nbits);
                end else
                    check("txn_len", nbits, exp_lens.pop_front());
                hi_cnt = 1; gap_armed = 1'b1;
            end else if (tm_stb) hi_cnt++;
        end
        prev_stb = tm_stb; prev_clk = tm_clk; prev_busy = busy; prev_done = frame_done;
    end

    // Stimulus helpers
    task automatic wait_busy();
        int n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 50);
        check("busy_start", int'(busy), 1);
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < 2 * PERIOD) begin @(negedge clk); n++; end
        check("done_seen", int'(done_cnt != start), 1);
    endtask

    task automatic set_inputs(input logic [31:0] d, input logic [7:0] l, input logic [2:0] b);
        data = d; leds = l; brightness = b;
    endtask

    task automatic run_frame(input logic [31:0] d, input logic [7:0] l, input logic [2:0] b);
        set_inputs(d, l, b);
        push_frame(d, l, b);
        enable = 1'b1;
        wait_busy();
        enable = 1'b0;
        // scramble inputs mid-frame; only the captured values may be sent
        set_inputs($urandom(), 8'($urandom()), 3'($urandom()));
        wait_done();
    endtask

    initial begin
        int d0;
        logic [31:0] d_old;

        // Reset held 3 cycles with enable low
        repeat (3) @(negedge clk);
        check("rst_stb", int'(tm_stb), 1);
        check("rst_clk", int'(tm_clk), 1);
        check("rst_dio", int'(tm_dio), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_no_done", done_cnt, 0);

        // Fixed patterns
        run_frame(32'h12345678, 8'h81, 3'd7);
        run_frame(32'hABCDEF00, 8'($urandom()), 3'($urandom()));

        // Inputs changed during CMD2, enable kept high for a second frame
        d_old = $urandom();
        set_inputs(d_old, 8'($urandom()), 3'($urandom()));
        push_frame(d_old, leds, brightness);
        enable = 1'b1;
        wait_busy();
        repeat (100) @(negedge clk);
        set_inputs(32'hFFFFFFFF, 8'($urandom()), 3'($urandom()));
        push_frame(data, leds, brightness);
        wait_done();
        wait_busy();
        enable = 1'b0;
        wait_done();

        // Reset around bit 50 of the address burst
        set_inputs($urandom(), 8'($urandom()), 3'($urandom()));
        push_frame(data, leds, brightness);
        enable = 1'b1;
        wait_busy();
        enable = 1'b0;
        repeat (238) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("abort_stb", int'(tm_stb), 1);
        check("abort_clk", int'(tm_clk), 1);
        check("abort_dio", int'(tm_dio), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(frame_done), 0);
        exp_bytes.delete();
        exp_lens.delete();
        frames_exp--;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        run_frame($urandom(), 8'($urandom()), 3'($urandom()));

        // Three back-to-back frames
        set_inputs($urandom(), 8'($urandom()), 3'($urandom()));
        for (int i = 0; i < 3; i++) push_frame(data, leds, brightness);
        done_times.delete();
        enable = 1'b1;
        wait_busy();
        wait_done();
        wait_done();
        wait_busy();
        enable = 1'b0;
        wait_done();
        check("b2b_count", done_times.size(), 3);
        if (done_times.size() == 3)
            for (int i = 1; i < 3; i++)
                check("b2b_period", done_times[i] - done_times[i-1], PERIOD);

        // Random frames
        for (int i = 0; i < 3; i++)
            run_frame($urandom(), 8'($urandom()), 3'($urandom()));

        repeat (10) @(negedge clk);
        check("left_bytes", exp_bytes.size(), 0);
        check("left_txns", exp_lens.size(), 0);
        check("frame_count", done_cnt, frames_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(500000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
